// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit hex 7-segment scan driver.
// Core logic writes a pending buffer with a load strobe. The pending data is
// promoted to the display buffer only at a frame boundary, so a frame always
// shows one consistent value. One digit is driven at a time. Each digit is held
// for REFRESH_DIV clocks. Per-digit decimal points, force-blank and
// leading-zero suppression are supported. All pin outputs are registered.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_suppress,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [PW-1:0] PS_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         prescaler;
  logic [IW-1:0]         idx;
  logic [VW-1:0]         disp_val;
  logic [NUM_DIGITS-1:0] disp_dp;
  logic [VW-1:0]         pend_val;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic                  pend_valid;

  logic                  tc;
  logic                  boundary;
  logic [IW-1:0]         idx_next;
  logic [VW-1:0]         frame_val;
  logic [NUM_DIGITS-1:0] frame_dp;
  logic [3:0]            nib;
  logic                  dp_req;
  logic                  blank_req;
  logic                  upper_zero;
  logic                  slot_blank;
  logic [NUM_DIGITS-1:0] an_next;

  // Hex nibble to active-low segment pattern {a,b,c,d,e,f,g}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0:    hex_to_seg = 7'b0000001;
      4'h1:    hex_to_seg = 7'b1001111;
      4'h2:    hex_to_seg = 7'b0010010;
      4'h3:    hex_to_seg = 7'b0000110;
      4'h4:    hex_to_seg = 7'b1001100;
      4'h5:    hex_to_seg = 7'b0100100;
      4'h6:    hex_to_seg = 7'b0100000;
      4'h7:    hex_to_seg = 7'b0001111;
      4'h8:    hex_to_seg = 7'b0000000;
      4'h9:    hex_to_seg = 7'b0000100;
      4'hA:    hex_to_seg = 7'b0001000;
      4'hB:    hex_to_seg = 7'b1100000;
      4'hC:    hex_to_seg = 7'b0110001;
      4'hD:    hex_to_seg = 7'b1000010;
      4'hE:    hex_to_seg = 7'b0110000;
      default: hex_to_seg = 7'b0111000;
    endcase
  endfunction

  assign tc       = (prescaler == PS_LAST);
  assign idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
  assign boundary = tc && (idx_next == '0);

  // Data the slot being entered decodes from. At a boundary this is the data
  // that becomes visible for the new frame, so digit 0 already shows it.
  always_comb begin
    frame_val = disp_val;
    frame_dp  = disp_dp;
    if (boundary) begin
      if (load) begin
        frame_val = value;
        frame_dp  = dp_in;
      end else if (pend_valid) begin
        frame_val = pend_val;
        frame_dp  = pend_dp;
      end
    end
  end

  // Select the entering digit's nibble and controls, and find leading zeros
  always_comb begin
    nib        = 4'h0;
    dp_req     = 1'b0;
    blank_req  = 1'b0;
    upper_zero = 1'b1;
    an_next    = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == idx_next) begin
        nib        = frame_val[4*i +: 4];
        dp_req     = frame_dp[i];
        blank_req  = blank_in[i];
        an_next[i] = 1'b0;
      end
      if ((IW'(i) >= idx_next) && (frame_val[4*i +: 4] != 4'h0))
        upper_zero = 1'b0;
    end
    slot_blank = blank_req || (lz_suppress && (idx_next != '0) && upper_zero);
  end

  // Slot timer and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      idx       <= IDX_LAST;
    end else if (tc) begin
      prescaler <= '0;
      idx       <= idx_next;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Pending/display buffers; display only changes at frame boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_val   <= '0;
      disp_dp    <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
    end else if (boundary) begin
      disp_val   <= frame_val;
      disp_dp    <= frame_dp;
      pend_valid <= 1'b0;
    end else if (load) begin
      pend_val   <= value;
      pend_dp    <= dp_in;
      pend_valid <= 1'b1;
    end
  end

  // Registered pin outputs, updated on every slot change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= '1;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= boundary;
      if (tc) begin
        if (slot_blank) begin
          an  <= '1;
          seg <= 7'b1111111;
          dp  <= 1'b1;
        end else begin
          an  <= an_next;
          seg <= hex_to_seg(nib);
          dp  <= ~dp_req;
        end
      end
    end
  end

endmodule
